// File: rtl/tile_writeback.sv
// Writeback stage for a tiled convolution: accumulates partial-sum beats into the
// output feature-map store with saturation and an optional ReLU on the last input tile.
//
// state | meaning
// IDLE  | waiting for start_i; fm_o holds the previous result
// RUN   | accepting partial-sum beats, one per cycle
// DONE  | layer complete; done_o pulses for one cycle
module tile_writeback #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2,
  parameter int W_p  = 32
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start_i,
  input  logic                                            relu_en_i,
  input  logic                                            psum_v_i,
  input  logic signed [Tm_p-1:0][W_p-1:0]                 psum_i,
  output logic                                            psum_ready_o,
  output logic signed [M_p-1:0][R_p-1:0][C_p-1:0][W_p-1:0] fm_o,
  output logic                                            busy_o,
  output logic                                            done_o
);

  localparam int TI_N = N_p / Tn_p;
  localparam int TO_N = M_p / Tm_p;
  localparam int CW   = (C_p  > 1) ? $clog2(C_p)  : 1;
  localparam int RW   = (R_p  > 1) ? $clog2(R_p)  : 1;
  localparam int IW   = (TI_N > 1) ? $clog2(TI_N) : 1;
  localparam int OW   = (TO_N > 1) ? $clog2(TO_N) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(C_p - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(R_p - 1);
  localparam logic [IW-1:0] TI_MAX  = IW'(TI_N - 1);
  localparam logic [OW-1:0] TO_MAX  = OW'(TO_N - 1);
  localparam logic [W_p-1:0] SAT_MAX = {1'b0, {(W_p-1){1'b1}}};
  localparam logic [W_p-1:0] SAT_MIN = {1'b1, {(W_p-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [IW-1:0]   ti_q, ti_d;
  logic [OW-1:0]   to_q, to_d;
  logic            relu_q, relu_d;
  logic            accept;
  logic [M_p-1:0][R_p-1:0][C_p-1:0][W_p-1:0] fm_q, fm_d;
  logic [W_p-1:0]  old_val [Tm_p];
  logic [W_p:0]    sum     [Tm_p];
  logic [W_p-1:0]  res     [Tm_p];

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    ti_d         = ti_q;
    to_d         = to_q;
    relu_d       = relu_q;
    accept       = 1'b0;
    psum_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          ti_d    = '0;
          to_d    = '0;
          relu_d  = relu_en_i;
        end
      end
      RUN: begin
        psum_ready_o = 1'b1;
        busy_o       = 1'b1;
        accept       = psum_v_i;
        if (accept) begin
          if (col_q == COL_MAX && row_q == ROW_MAX && ti_q == TI_MAX && to_q == TO_MAX)
            state_d = DONE;
          if (col_q != COL_MAX) col_d = col_q + CW'(1);
          else begin
            col_d = '0;
            if (row_q != ROW_MAX) row_d = row_q + RW'(1);
            else begin
              row_d = '0;
              if (ti_q != TI_MAX) ti_d = ti_q + IW'(1);
              else begin
                ti_d = '0;
                to_d = (to_q != TO_MAX) ? to_q + OW'(1) : '0;
              end
            end
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gather the Tm_p targets, compute new values, then scatter them back.
  always_comb begin
    for (int k = 0; k < Tm_p; k++) begin
      old_val[k] = '0;
      sum[k]     = '0;
      res[k]     = '0;
    end
    fm_d = fm_q;
    for (int m = 0; m < M_p; m++)
      for (int r = 0; r < R_p; r++)
        for (int c = 0; c < C_p; c++)
          if (m / Tm_p == int'(to_q) && r == int'(row_q) && c == int'(col_q))
            old_val[m % Tm_p] = fm_q[m][r][c];
    for (int k = 0; k < Tm_p; k++) begin
      sum[k] = {old_val[k][W_p-1], old_val[k]} + {psum_i[k][W_p-1], psum_i[k]};
      if (ti_q == '0)
        res[k] = psum_i[k];
      else if (sum[k][W_p] != sum[k][W_p-1])
        res[k] = sum[k][W_p] ? SAT_MIN : SAT_MAX;
      else
        res[k] = sum[k][W_p-1:0];
      if (ti_q == TI_MAX && relu_q && res[k][W_p-1])
        res[k] = '0;
    end
    for (int m = 0; m < M_p; m++)
      for (int r = 0; r < R_p; r++)
        for (int c = 0; c < C_p; c++)
          if (accept && m / Tm_p == int'(to_q) && r == int'(row_q) && c == int'(col_q))
            fm_d[m][r][c] = res[m % Tm_p];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ti_q    <= '0;
      to_q    <= '0;
      relu_q  <= 1'b0;
      fm_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ti_q    <= ti_d;
      to_q    <= to_d;
      relu_q  <= relu_d;
      fm_q    <= fm_d;
    end
  end

  assign fm_o = fm_q;

endmodule

// File: tb/tb_tile_writeback.sv
// Directed self-checking bench for tile_writeback with a 4x4x2x2 layer (16 beats).
module tb_tile_writeback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_i, relu_en_i, psum_v_i;
  logic [1:0][31:0] psum;
  logic ready, busy, done;
  logic [3:0][1:0][1:0][31:0] fm;
  int checks = 0;
  int errors = 0;

  tile_writeback #(.N_p(4), .M_p(4), .R_p(2), .C_p(2), .Tn_p(2), .Tm_p(2), .W_p(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .relu_en_i(relu_en_i),
    .psum_v_i(psum_v_i), .psum_i(psum), .psum_ready_o(ready),
    .fm_o(fm), .busy_o(busy), .done_o(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fm(input string tag, input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e;
    for (int ch = 0; ch < 4; ch++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          e = (ch == 0) ? e0 : (ch == 1) ? e1 : (ch == 2) ? e2 : e3;
          chk($sformatf("%s_fm[%0d][%0d][%0d]", tag, ch, r, c), fm[ch][r][c], e);
        end
  endtask

  // x: ti=0 values, y: ti=1 values for to=0, z: ti=1 values for to=1.
  // start_i is also raised mid-RUN and during DONE; both must be ignored.
  task automatic run_layer(input string tag, input bit relu, input bit gap,
                           input logic [31:0] x0, x1, y0, y1, z0, z1);
    start_i = 1'b1; relu_en_i = relu;
    tick();
    start_i = 1'b0; relu_en_i = ~relu;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_ready_run"}, ready, 1);
    for (int b = 0; b < 16; b++) begin
      if (((b / 4) % 2) == 0) begin psum[0] = x0; psum[1] = x1; end
      else if (b < 8)         begin psum[0] = y0; psum[1] = y1; end
      else                    begin psum[0] = z0; psum[1] = z1; end
      psum_v_i = 1'b1;
      start_i  = (b == 5);
      tick();
      psum_v_i = 1'b0;
      start_i  = 1'b0;
      if (b < 15) begin
        chk($sformatf("%s_done_early_b%0d", tag, b), done, 0);
        if (gap) begin
          psum[0] = $urandom; psum[1] = $urandom;
          tick();
        end
      end
    end
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_ready_done"}, ready, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_start_in_done_ignored"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b1; relu_en_i = 1'b1; psum_v_i = 1'b1;
    psum[0] = 32'd5; psum[1] = 32'd5;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk_fm("rst", 0, 0, 0, 0);
    start_i = 1'b0; psum_v_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);

    run_layer("basic", 1'b0, 1'b0, 1, 2, 1, 2, 1, 2);
    chk_fm("basic", 2, 4, 2, 4);

    run_layer("relu", 1'b1, 1'b0, 5, -3, -10, 1, -4, 4);
    chk_fm("relu", 0, 0, 1, 1);

    run_layer("sat", 1'b0, 1'b0, 32'h7FFFFFF0, 32'h80000010, 32'h100, -256, 0, 0);
    chk_fm("sat", 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFF0, 32'h80000010);

    psum[0] = 32'd9; psum[1] = 32'd9; psum_v_i = 1'b1;
    tick(); tick();
    psum_v_i = 1'b0;
    chk("idle_beat_busy", busy, 0);
    chk("idle_beat_fm0", fm[0][0][0], 32'h7FFFFFFF);
    chk("idle_beat_fm1", fm[1][1][1], 32'h80000000);
    run_layer("gaps", 1'b0, 1'b1, 1, 2, 1, 2, 1, 2);
    chk_fm("gaps", 2, 4, 2, 4);

    start_i = 1'b1; relu_en_i = 1'b1;
    tick();
    start_i = 1'b0;
    psum[0] = 32'd8; psum[1] = -8; psum_v_i = 1'b1;
    for (int b = 0; b < 7; b++) begin
      tick();
      if (b == 0) chk("part_latency", fm[0][0][0], 8);
      if (b == 3) chk("part_no_relu_ti0", fm[1][1][1], 32'hFFFFFFF8);
    end
    chk("part_acc", fm[0][0][0], 16);
    chk("part_relu", fm[1][0][0], 0);
    chk("part_untouched", fm[1][1][1], 32'hFFFFFFF8);
    reset = 1'b0; start_i = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_done", done, 0);
    chk_fm("midrst", 0, 0, 0, 0);
    reset = 1'b1; start_i = 1'b0; psum_v_i = 1'b0;
    tick();
    run_layer("after_rst", 1'b0, 1'b0, 3, 3, 3, 3, 3, 3);
    chk_fm("after_rst", 6, 6, 6, 6);

    run_layer("stale", 1'b0, 1'b0, 10, -1, 1, 1, 1, 1);
    chk_fm("stale", 11, 0, 11, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
